// File: rtl/tx_serializer_if.sv
// Word-in / byte-out handshake bundle between the capture controller, the serializer and the UART.
// The serializer connects through the slave modport; the environment driving it uses master.
interface tx_serializer_if #(
  parameter int NBYTES = 4
) ();
  logic                  tx_stb_i;
  logic [8*NBYTES-1:0]   tx_i;
  logic                  tx_rdy_o;
  logic [7:0]            byte_o;
  logic                  byte_vld_o;
  logic                  byte_rdy_i;

  modport slave (
    input  tx_stb_i, tx_i, byte_rdy_i,
    output tx_rdy_o, byte_o, byte_vld_o
  );

  modport master (
    output tx_stb_i, tx_i, byte_rdy_i,
    input  tx_rdy_o, byte_o, byte_vld_o
  );
endinterface

// File: rtl/tx_serializer.sv
// Splits controller readout words into bytes, LSB first, and emits only the bytes whose
// channel group is enabled, over a valid/ready byte interface to the UART transmitter.
module tx_serializer #(
  parameter int NBYTES = 4
) (
  input  logic              clk_i,
  input  logic              rst_in,
  input  logic [NBYTES-1:0] grp_en_i,
  tx_serializer_if.slave    bus,
  output logic              busy_o
);

  localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  state_t              state_q, state_d;
  logic [8*NBYTES-1:0] word_q;
  logic [NBYTES-1:0]   mask_q;
  logic [IW-1:0]       idx_q;

  logic                accept;
  logic                xfer;
  logic [NBYTES-1:0]   mask_clr;

  function automatic logic [IW-1:0] lowest_set(input logic [NBYTES-1:0] m);
    logic [IW-1:0] r;
    r = '0;
    for (int i = NBYTES - 1; i >= 0; i--) begin
      if (m[i]) r = IW'(i);
    end
    return r;
  endfunction

  assign accept   = (state_q == IDLE) && bus.tx_stb_i;
  assign xfer     = (state_q == SEND) && bus.byte_rdy_i;
  assign mask_clr = mask_q & ~(NBYTES'(1) << idx_q);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (!rst_in) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d        = state_q;
    bus.tx_rdy_o   = 1'b0;
    bus.byte_vld_o = 1'b0;
    busy_o         = 1'b0;
    unique case (state_q)
      IDLE: begin
        bus.tx_rdy_o = 1'b1;
        if (bus.tx_stb_i && (grp_en_i != '0)) state_d = SEND;
      end
      SEND: begin
        bus.byte_vld_o = 1'b1;
        busy_o         = 1'b1;
        if (bus.byte_rdy_i && (mask_clr == '0)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: the word and mask are plain registers, so clearing them in reset is cheap and keeps
  // byte_o at a defined zero out of reset.
  always_ff @(posedge clk_i) begin
    if (!rst_in) begin
      word_q <= '0;
      mask_q <= '0;
      idx_q  <= '0;
    end else if (accept) begin
      word_q <= bus.tx_i;
      mask_q <= grp_en_i;
      idx_q  <= lowest_set(grp_en_i);
    end else if (xfer) begin
      mask_q <= mask_clr;
      // Keep idx on the final byte so byte_o holds its last value while idle.
      if (mask_clr != '0) idx_q <= lowest_set(mask_clr);
    end
  end

  assign bus.byte_o = word_q[{idx_q, 3'b000} +: 8];

endmodule

// File: tb/tb_tx_serializer.sv
// Bench for tx_serializer: directed scenarios plus a randomized run scored against a
// byte-list model built from the accepted words and their group masks.
module tb_tx_serializer;

  localparam int NBYTES = 4;

  logic              clk_i = 1'b0;
  logic              rst_in;
  logic [NBYTES-1:0] grp_en_i;
  logic              busy_o;

  tx_serializer_if #(.NBYTES(NBYTES)) ifc ();

  tx_serializer #(.NBYTES(NBYTES)) dut (
    .clk_i    (clk_i),
    .rst_in   (rst_in),
    .grp_en_i (grp_en_i),
    .bus      (ifc.slave),
    .busy_o   (busy_o)
  );

  always #5 clk_i = ~clk_i;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];

  // Reference: enabled bytes of a word in ascending byte order.
  task automatic model_push(input logic [8*NBYTES-1:0] w, input logic [NBYTES-1:0] m);
    for (int k = 0; k < NBYTES; k++)
      if (m[k]) exp_q.push_back(8'((w >> (8 * k)) & 32'hFF));
  endtask

  // One clock: record the transfer about to happen at the coming edge, then move to the next negedge.
  task automatic cyc();
    if (ifc.byte_vld_o === 1'b1 && ifc.byte_rdy_i && rst_in) got_q.push_back(ifc.byte_o);
    @(negedge clk_i);
  endtask

  task automatic strobe(input logic [8*NBYTES-1:0] w, input logic [NBYTES-1:0] m);
    ifc.tx_stb_i = 1'b1;
    ifc.tx_i     = w;
    grp_en_i     = m;
    cyc();
    ifc.tx_stb_i = 1'b0;
  endtask

  task automatic drain(input string name);
    int budget = 200;
    ifc.byte_rdy_i = 1'b1;
    while (!(ifc.tx_rdy_o === 1'b1 && ifc.byte_vld_o === 1'b0) && budget > 0) begin
      cyc();
      budget--;
    end
    n_tests++;
    if (budget == 0) begin
      n_fail++;
      $display("FAIL %s_drain: serializer did not return idle within 200 cycles", name);
    end
  endtask

  task automatic test_reset();
    rst_in = 1'b0;
    repeat (2) @(negedge clk_i);
    n_tests++;
    if ({ifc.tx_rdy_o, ifc.byte_vld_o, busy_o, ifc.byte_o} !== {1'b1, 1'b0, 1'b0, 8'h00}) begin
      n_fail++;
      $display("FAIL reset: rdy/vld/busy/byte got %b%b%b %h want 1 0 0 00",
               ifc.tx_rdy_o, ifc.byte_vld_o, busy_o, ifc.byte_o);
    end
    rst_in = 1'b1;
    @(negedge clk_i);
  endtask

  task automatic test_full_mask();
    logic [7:0] want [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    ifc.byte_rdy_i = 1'b1;
    strobe(32'h44332211, 4'b1111);
    for (int k = 0; k < 4; k++) begin
      n_tests++;
      if (ifc.byte_vld_o !== 1'b1 || ifc.byte_o !== want[k] || busy_o !== 1'b1 || ifc.tx_rdy_o !== 1'b0) begin
        n_fail++;
        $display("FAIL full_byte%0d: vld=%b byte=%h busy=%b rdy=%b want vld=1 byte=%h busy=1 rdy=0",
                 k, ifc.byte_vld_o, ifc.byte_o, busy_o, ifc.tx_rdy_o, want[k]);
      end
      cyc();
    end
    n_tests++;
    if (ifc.tx_rdy_o !== 1'b1 || ifc.byte_vld_o !== 1'b0 || busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL full_idle: rdy=%b vld=%b busy=%b want 1 0 0", ifc.tx_rdy_o, ifc.byte_vld_o, busy_o);
    end
  endtask

  task automatic test_sparse_mask();
    got_q.delete();
    ifc.byte_rdy_i = 1'b1;
    strobe(32'hDDCCBBAA, 4'b1010);
    repeat (4) cyc();
    n_tests++;
    if (got_q.size() != 2 || got_q[0] !== 8'hBB || got_q[1] !== 8'hDD) begin
      n_fail++;
      $display("FAIL sparse: got %0d bytes %p want 2 bytes BB DD", got_q.size(), got_q);
    end
  endtask

  task automatic test_empty_mask();
    strobe(32'hFFFFFFFF, 4'b0000);
    n_tests++;
    if (ifc.byte_vld_o !== 1'b0 || ifc.tx_rdy_o !== 1'b1 || busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL empty_drop: vld=%b rdy=%b busy=%b want 0 1 0", ifc.byte_vld_o, ifc.tx_rdy_o, busy_o);
    end
    strobe(32'h0000_00A5, 4'b0001);
    n_tests++;
    if (ifc.byte_vld_o !== 1'b1 || ifc.byte_o !== 8'hA5) begin
      n_fail++;
      $display("FAIL empty_next: vld=%b byte=%h want vld=1 byte=a5", ifc.byte_vld_o, ifc.byte_o);
    end
    drain("empty");
  endtask

  task automatic test_backpressure();
    logic [7:0] rdy_pat = 8'b1011_0100;  // bit k is byte_rdy_i in cycle k: 0,0,1,0,1,1,0,1
    logic [7:0] held;
    got_q.delete();
    ifc.byte_rdy_i = 1'b0;
    strobe(32'h04030201, 4'b1111);
    held = ifc.byte_o;
    for (int k = 0; k < 8; k++) begin
      if (k > 0 && !rdy_pat[k-1]) begin
        n_tests++;
        if (ifc.byte_vld_o !== 1'b1 || ifc.byte_o !== held) begin
          n_fail++;
          $display("FAIL bp_stable%0d: vld=%b byte=%h want vld=1 byte=%h", k, ifc.byte_vld_o, ifc.byte_o, held);
        end
      end
      held = ifc.byte_o;
      ifc.byte_rdy_i = rdy_pat[k];
      cyc();
    end
    ifc.byte_rdy_i = 1'b1;
    n_tests++;
    if (got_q.size() != 4 || got_q[0] !== 8'h01 || got_q[1] !== 8'h02 ||
        got_q[2] !== 8'h03 || got_q[3] !== 8'h04 || ifc.tx_rdy_o !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_sequence: got %p rdy=%b want 01 02 03 04 rdy=1", got_q, ifc.tx_rdy_o);
    end
  endtask

  task automatic test_strobe_busy();
    got_q.delete();
    ifc.byte_rdy_i = 1'b1;
    strobe(32'h44332211, 4'b1111);
    ifc.tx_stb_i = 1'b1;
    ifc.tx_i     = 32'h55555555;
    repeat (2) cyc();
    ifc.tx_stb_i = 1'b0;
    repeat (3) cyc();
    n_tests++;
    if (got_q.size() != 4 || got_q[0] !== 8'h11 || got_q[1] !== 8'h22 ||
        got_q[2] !== 8'h33 || got_q[3] !== 8'h44) begin
      n_fail++;
      $display("FAIL strobe_busy: got %p want 11 22 33 44", got_q);
    end
  endtask

  task automatic test_reset_mid_send();
    got_q.delete();
    ifc.byte_rdy_i = 1'b1;
    strobe(32'h44332211, 4'b1111);
    cyc();
    rst_in = 1'b0;
    cyc();
    rst_in = 1'b1;
    n_tests++;
    if (ifc.byte_vld_o !== 1'b0 || ifc.tx_rdy_o !== 1'b1 || busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_state: vld=%b rdy=%b busy=%b want 0 1 0", ifc.byte_vld_o, ifc.tx_rdy_o, busy_o);
    end
    repeat (4) cyc();
    n_tests++;
    if (got_q.size() != 1 || got_q[0] !== 8'h11) begin
      n_fail++;
      $display("FAIL rst_mid_discard: got %p want only 11", got_q);
    end
    got_q.delete();
    strobe(32'h0D0C0B0A, 4'b1101);
    drain("rst_mid");
    n_tests++;
    if (got_q.size() != 3 || got_q[0] !== 8'h0A || got_q[1] !== 8'h0C || got_q[2] !== 8'h0D) begin
      n_fail++;
      $display("FAIL rst_mid_resume: got %p want 0a 0c 0d", got_q);
    end
  endtask

  task automatic test_random();
    got_q.delete();
    exp_q.delete();
    for (int c = 0; c < 1500; c++) begin
      ifc.byte_rdy_i = ($urandom_range(0, 3) != 0);
      ifc.tx_stb_i   = ($urandom_range(0, 2) == 0);
      ifc.tx_i       = $urandom();
      grp_en_i       = 4'($urandom_range(0, 15));
      if (ifc.tx_stb_i && ifc.tx_rdy_o === 1'b1) model_push(ifc.tx_i, grp_en_i);
      cyc();
    end
    ifc.tx_stb_i = 1'b0;
    drain("random");
    n_tests++;
    if (got_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL random_count: got %0d bytes want %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_tests++;
      if (got_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL random_byte%0d: got %h want %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  initial begin
    rst_in         = 1'b0;
    grp_en_i       = '0;
    ifc.tx_stb_i   = 1'b0;
    ifc.tx_i       = '0;
    ifc.byte_rdy_i = 1'b0;
    @(negedge clk_i);
    test_reset();
    test_full_mask();
    test_sparse_mask();
    test_empty_mask();
    test_backpressure();
    test_strobe_busy();
    test_reset_mid_send();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/tx_serializer.md
Name: tx_serializer

Overview:
- Sits directly downstream of the capture controller (`ctrl`). Consumes the controller's 32-bit readout words (`tx_o`/`tx_stb_o`) and drives the controller's `tx_rdy_i`.
- Splits each accepted word into bytes, least-significant byte first, and hands them one at a time to the UART transmitter over a valid/ready byte interface.
- Skips bytes whose channel group is disabled, so only enabled groups go to the host (SUMP group-disable flags).

Parameters:
- NBYTES, 4, bytes per input word; word width is 8*NBYTES.

Ports:
- clk_i  input  1  system clock; all logic on rising edge.
- rst_in  input  1  reset; synchronous, active-low.
- grp_en_i  input  NBYTES  group enable mask; bit k=1 means byte k is sent. Sampled only at word accept.
- tx_stb_i  input  1  word strobe from `ctrl` (`tx_stb_o`).
- tx_i  input  8*NBYTES  word from `ctrl` (`tx_o`).
- tx_rdy_o  output  1  ready to accept a word; drives `ctrl.tx_rdy_i`.
- byte_o  output  8  byte to UART transmitter.
- byte_vld_o  output  1  `byte_o` valid.
- byte_rdy_i  input  1  UART transmitter can take a byte.
- busy_o  output  1  word in flight (state SEND).

Behaviour:
- Reset (rst_in=0 at a rising edge):
  - State goes to IDLE.
  - Outputs: tx_rdy_o=1, byte_vld_o=0, byte_o=0, busy_o=0.
  - Internal word and mask registers clear to 0.
  - Reset overrides everything, including mid-send; a partially sent word is discarded and no further bytes of it are emitted.
- IDLE:
  - tx_rdy_o=1, byte_vld_o=0.
  - Word accept = tx_stb_i=1 at a rising edge while tx_rdy_o=1. On accept, latch tx_i into the word register and grp_en_i into the pending mask.
  - If grp_en_i==0, stay IDLE and drop the word; tx_rdy_o remains 1 and no byte is emitted.
  - Otherwise go to SEND with byte index = lowest set bit of the mask.
- SEND:
  - tx_rdy_o=0, busy_o=1.
  - byte_o = word[8*idx +: 8]; byte_vld_o=1 from the first cycle after accept (latency 1).
  - byte_vld_o and byte_o stay stable until the transfer completes. Transfer = byte_vld_o & byte_rdy_i at a rising edge.
  - On transfer, clear mask bit idx and move idx to the next higher set bit. byte_vld_o stays 1 with no bubble between bytes.
  - When the transfer consumes the last set bit, go to IDLE: byte_vld_o=0 and tx_rdy_o=1 on the next cycle. The next word can be accepted at the edge after that.
  - byte_rdy_i low holds state indefinitely with no timeout.
- tx_stb_i while tx_rdy_o=0 is ignored. No buffering, no error flag; the controller must respect tx_rdy_o.
- grp_en_i changes during SEND do not affect the word in flight.
- Throughput: each word of k enabled bytes occupies k+1 cycles minimum: 1 accept cycle plus k transfer cycles.
- byte_o holds its last value when byte_vld_o=0. Checkers must treat it as don't-care.

Test Plan:
- Full mask: grp_en_i=4'b1111, tx_i=32'h44332211 strobed, byte_rdy_i=1 → bytes 8'h11, 8'h22, 8'h33, 8'h44 on consecutive cycles starting 1 cycle after accept; tx_rdy_o back to 1 the cycle after the 8'h44 transfer.
- Sparse mask: grp_en_i=4'b1010, tx_i=32'hDDCCBBAA → only 8'hBB then 8'hDD; exactly 2 transfers.
- Empty mask: grp_en_i=4'b0000, tx_i=32'hFFFFFFFF strobed → byte_vld_o never asserts; tx_rdy_o stays 1; next word accepted the following cycle.
- Backpressure: mask 4'b1111, tx_i=32'h04030201, byte_rdy_i toggled 0,0,1,0,1,1,0,1 → byte_o stable while stalled; sequence 01,02,03,04 with no loss or duplicate.
- Strobe while busy: second strobe with 32'h55555555 during SEND → ignored; only the first word's bytes appear.
- Reset mid-send: rst_in=0 for one cycle after byte 8'h11 of 32'h44332211 → next cycle byte_vld_o=0, tx_rdy_o=1, busy_o=0; no 8'h22/33/44 afterwards; a new word sends correctly.
